// File: rtl/func_sequencer.sv
// Execute-stage sequencer: accepts one function code per handshake and drives the ALU/shifter/multiplier op bus.
// Build option: define FUNC_SEQ_ILLEGAL_TRAP_EN to flag illegal function codes on err during their EXEC cycle.
module func_sequencer #(
    parameter int unsigned MUL_CYCLES = 32,
    parameter int unsigned FUNCT_W    = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [FUNCT_W-1:0] funct,
    output logic [FUNCT_W-1:0] op,
    output logic               mul_load,
    output logic               mul_step,
    output logic               hilo_we,
    output logic               rf_we,
    output logic               done,
    output logic               err
);

    localparam int unsigned CNT_W = $clog2(MUL_CYCLES + 1);

    localparam logic [FUNCT_W-1:0] F_SRL   = FUNCT_W'(2);
    localparam logic [FUNCT_W-1:0] F_MFHI  = FUNCT_W'(16);
    localparam logic [FUNCT_W-1:0] F_MFLO  = FUNCT_W'(18);
    localparam logic [FUNCT_W-1:0] F_MULTU = FUNCT_W'(25);
    localparam logic [FUNCT_W-1:0] F_ADD   = FUNCT_W'(32);
    localparam logic [FUNCT_W-1:0] F_SUB   = FUNCT_W'(34);
    localparam logic [FUNCT_W-1:0] F_AND   = FUNCT_W'(36);
    localparam logic [FUNCT_W-1:0] F_OR    = FUNCT_W'(37);
    localparam logic [FUNCT_W-1:0] F_SLT   = FUNCT_W'(42);
    localparam logic [FUNCT_W-1:0] F_MDONE = '1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        MUL  = 2'd2,
        HILO = 2'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] count;

    // Single-cycle codes; MULTU is routed to the multiplier path before this is consulted.
    function automatic logic is_legal(input logic [FUNCT_W-1:0] f);
        case (f)
            F_SRL, F_MFHI, F_MFLO, F_ADD, F_SUB,
            F_AND, F_OR, F_SLT: is_legal = 1'b1;
            default:            is_legal = 1'b0;
        endcase
    endfunction

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            count     <= '0;
            req_ready <= 1'b1;
            op        <= '0;
            mul_load  <= 1'b0;
            mul_step  <= 1'b0;
            hilo_we   <= 1'b0;
            rf_we     <= 1'b0;
            done      <= 1'b0;
`ifdef FUNC_SEQ_ILLEGAL_TRAP_EN
            err       <= 1'b0;
`endif
        end else begin
            req_ready <= 1'b0;
            op        <= '0;
            mul_load  <= 1'b0;
            mul_step  <= 1'b0;
            hilo_we   <= 1'b0;
            rf_we     <= 1'b0;
            done      <= 1'b0;
`ifdef FUNC_SEQ_ILLEGAL_TRAP_EN
            err       <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (funct == F_MULTU) begin
                            state    <= MUL;
                            count    <= '0;
                            op       <= F_MULTU;
                            mul_load <= 1'b1;
                            mul_step <= 1'b1;
                        end else begin
                            state <= EXEC;
                            done  <= 1'b1;
                            if (is_legal(funct)) begin
                                op    <= funct;
                                rf_we <= 1'b1;
                            end
`ifdef FUNC_SEQ_ILLEGAL_TRAP_EN
                            err <= ~is_legal(funct);
`endif
                        end
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                EXEC: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
                MUL: begin
                    if (count == CNT_LAST) begin
                        state   <= HILO;
                        count   <= '0;
                        op      <= F_MDONE;
                        hilo_we <= 1'b1;
                        done    <= 1'b1;
                    end else begin
                        count    <= count + CNT_W'(1);
                        op       <= F_MULTU;
                        mul_step <= 1'b1;
                    end
                end
                HILO: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

`ifndef FUNC_SEQ_ILLEGAL_TRAP_EN
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_func_sequencer.sv
// Directed bench for func_sequencer at MUL_CYCLES=32: reset, single-cycle ops, MULTU timing, abort and illegal codes.
module tb_func_sequencer;

    logic       clk;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    logic [5:0] funct;
    logic [5:0] op;
    logic       mul_load;
    logic       mul_step;
    logic       hilo_we;
    logic       rf_we;
    logic       done;
    logic       err;

    int tests;
    int fails;

    func_sequencer #(.MUL_CYCLES(32), .FUNCT_W(6)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .funct     (funct),
        .op        (op),
        .mul_load  (mul_load),
        .mul_step  (mul_step),
        .hilo_we   (hilo_we),
        .rf_we     (rf_we),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_ready"}, int'(req_ready), 1);
        check({tag, "_op"},    int'(op),        0);
        check({tag, "_done"},  int'(done),      0);
        check({tag, "_rfwe"},  int'(rf_we),     0);
        check({tag, "_hilo"},  int'(hilo_we),   0);
        check({tag, "_step"},  int'(mul_step),  0);
        check({tag, "_load"},  int'(mul_load),  0);
        check({tag, "_err"},   int'(err),       0);
    endtask

    initial begin
        int steps;
        int loads;
        int hilos;
        int dones;
        int badop;
        int exp_err;
        logic [5:0] seq [6];

        tests = 0;
        fails = 0;
`ifdef FUNC_SEQ_ILLEGAL_TRAP_EN
        exp_err = 1;
`else
        exp_err = 0;
`endif
        seq[0] = 6'd36; seq[1] = 6'd37; seq[2] = 6'd42;
        seq[3] = 6'd2;  seq[4] = 6'd16; seq[5] = 6'd18;

        // Reset with a request present: must not be accepted.
        reset = 1'b1; req_valid = 1'b1; funct = 6'd32;
        tick();
        check_idle("reset");

        // ADD accepted at the first edge after reset release.
        reset = 1'b0;
        tick();
        req_valid = 1'b0;
        check("add_op",    int'(op),        32);
        check("add_rfwe",  int'(rf_we),     1);
        check("add_done",  int'(done),      1);
        check("add_ready", int'(req_ready), 0);
        tick();
        check_idle("add_after");

        // MULTU: 32 step cycles, load only in the first, then one HILO cycle.
        req_valid = 1'b1; funct = 6'd25;
        tick();
        req_valid = 1'b0;
        steps = int'(mul_step); loads = int'(mul_load); hilos = int'(hilo_we);
        check("mul_first_op",   int'(op),       25);
        check("mul_first_load", int'(mul_load), 1);
        badop = 0;
        for (int c = 2; c <= 32; c++) begin
            tick();
            if (c == 5) begin
                req_valid = 1'b1; funct = 6'd36;
            end
            steps += int'(mul_step);
            loads += int'(mul_load);
            hilos += int'(hilo_we);
            if (op != 6'd25 || req_ready || done) badop++;
        end
        check("mul_steps",  steps, 32);
        check("mul_loads",  loads, 1);
        check("mul_badcyc", badop, 0);
        tick();
        hilos += int'(hilo_we);
        check("hilo_op",   int'(op),       63);
        check("hilo_we",   int'(hilo_we),  1);
        check("hilo_done", int'(done),     1);
        check("hilo_step", int'(mul_step), 0);
        check("hilo_ready", int'(req_ready), 0);
        tick();
        hilos += int'(hilo_we);
        check("mul_end_ready", int'(req_ready), 1);
        check("mul_end_op",    int'(op),        0);
        check("mul_hilo_cnt",  hilos,           1);
        // Request held since T+5 is accepted only now.
        tick();
        req_valid = 1'b0;
        check("held_and_op",   int'(op),    36);
        check("held_and_rfwe", int'(rf_we), 1);
        tick();
        check_idle("held_after");

        // Reset asserted at T+10 of a MULTU aborts it.
        req_valid = 1'b1; funct = 6'd25;
        tick();
        req_valid = 1'b0;
        for (int c = 2; c <= 10; c++) tick();
        check("abort_step_pre", int'(mul_step), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_idle("abort");
        hilos = 0; dones = 0;
        for (int c = 0; c < 30; c++) begin
            tick();
            hilos += int'(hilo_we);
            dones += int'(done);
        end
        check("abort_hilo", hilos, 0);
        check("abort_done", dones, 0);
        req_valid = 1'b1; funct = 6'd34;
        tick();
        req_valid = 1'b0;
        check("sub_op",   int'(op),    34);
        check("sub_rfwe", int'(rf_we), 1);
        check("sub_done", int'(done),  1);
        tick();
        check_idle("sub_after");

        // Illegal code 7.
        req_valid = 1'b1; funct = 6'd7;
        tick();
        req_valid = 1'b0;
        check("ill_op",   int'(op),    0);
        check("ill_rfwe", int'(rf_we), 0);
        check("ill_done", int'(done),  1);
        check("ill_err",  int'(err),   exp_err);
        tick();
        check_idle("ill_after");

        // Back-to-back single-cycle ops with req_valid held high.
        req_valid = 1'b1; funct = seq[0];
        for (int k = 0; k < 6; k++) begin
            tick();
            check($sformatf("b2b%0d_op", k),   int'(op),        int'(seq[k]));
            check($sformatf("b2b%0d_rfwe", k), int'(rf_we),     1);
            check($sformatf("b2b%0d_done", k), int'(done),      1);
            if (k < 5) funct = seq[k+1];
            else       req_valid = 1'b0;
            tick();
            check($sformatf("b2b%0d_gap_ready", k), int'(req_ready), 1);
            check($sformatf("b2b%0d_gap_op", k),    int'(op),        0);
        end
        tick();
        check_idle("final");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
